// File: rtl/shift_unit_seq_if.sv
// Handshake and data bundle between the execute stage and the sequential shifter.
// The master side issues start/op/shamt_in/data_in; the slave side (the shifter)
// answers with busy/done/result.
interface shift_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] shamt_in;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, shamt_in, data_in,
    input  busy, done, result
  );

  modport slave (
    input  start, op, shamt_in, data_in,
    output busy, done, result
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle logarithmic shifter for the MIPS execute path.
// One log2 stage (1, 2, 4, 8, 16) is applied per clock under a
// start/busy/done handshake; result is registered and held until the
// next completion.
// op: 00=SLL, 01=SRL, 11=SRA, 10 behaves as SRL.
// Optional macro SHIFT_EARLY_DONE_EN: finish as soon as no higher shift
// amount bits remain (shamt==0 completes straight from IDLE).
module shift_unit_seq #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input logic            clk,
  input logic            rst,
  shift_unit_seq_if.slave bus
);

  localparam int CNT_W = $clog2(STAGES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [STAGES-1:0]  shamt_q;
  logic [WIDTH-1:0]   stage_out;
  logic               last_stage;

  // Only the low log2(WIDTH) bits of the shift amount are meaningful.
  logic unused_shamt_hi;
  assign unused_shamt_hi = ^bus.shamt_in[WIDTH-1:STAGES];

  // Apply the fixed-distance shift selected by the current stage, if its amount bit is set.
  always_comb begin
    stage_out = work;
    for (int s = 0; s < STAGES; s++) begin
      if (int'(cnt) == s && shamt_q[s]) begin
        case (op_q)
          2'b00:   stage_out = work << (1 << s);
          2'b11:   stage_out = $signed(work) >>> (1 << s);
          default: stage_out = work >> (1 << s);
        endcase
      end
    end
  end

  // Decide whether the stage being applied this cycle is the final one.
  always_comb begin
`ifdef SHIFT_EARLY_DONE_EN
    last_stage = ((shamt_q >> cnt) >> 1) == '0;
`else
    last_stage = (cnt == CNT_W'(STAGES - 1));
`endif
  end

  // Control FSM with registered busy/done/result; reset aborts any shift in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      work       <= '0;
      cnt        <= '0;
      op_q       <= '0;
      shamt_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            work     <= bus.data_in;
            op_q     <= bus.op;
            shamt_q  <= bus.shamt_in[STAGES-1:0];
            cnt      <= '0;
            bus.busy <= 1'b1;
`ifdef SHIFT_EARLY_DONE_EN
            if (bus.shamt_in[STAGES-1:0] == '0) begin
              bus.result <= bus.data_in;
              bus.done   <= 1'b1;
              state      <= S_DONE;
            end else begin
              state <= S_SHIFT;
            end
`else
            state <= S_SHIFT;
`endif
          end
        end

        S_SHIFT: begin
          work <= stage_out;
          cnt  <= cnt + CNT_W'(1);
          if (last_stage) begin
            bus.result <= stage_out;
            bus.done   <= 1'b1;
            state      <= S_DONE;
          end
        end

        S_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Multi-cycle logarithmic shifter in the execute path of the 54-instruction MIPS core.
- Consumes the 32-bit zero-extended shift amount produced by the 5-bit extender (sll/srl/sra), or rs for the variable forms (sllv/srlv/srav).
- Applies one log2 stage (shift by 1, 2, 4, 8, 16) per clock under a start/busy/done handshake.
- Returns the shifted word to the ALU result mux.

Parameters:
- WIDTH, 32, data width; shift-amount field width is log2(WIDTH)=5.
- STAGES, 5, number of log2 stages; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00=SLL, 01=SRL, 11=SRA, 10=reserved (behaves as SRL)
- shamt_in  input  32  shift amount; only [4:0] used, [31:5] ignored
- data_in  input  32  operand (rt)
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; result valid
- result  output  32  shifted word; registered; holds until next completion

Behaviour:
- One clock. Reset is synchronous and active-high; clock port is clk, reset port is rst.
- Reset (any state, including mid-shift):
  - state=IDLE; busy=0, done=0, result=0.
  - Working register, stage counter, and latched op/shamt are cleared.
  - No done is produced for the aborted operation.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at the edge: latch data_in into work, op, and shamt_in[4:0]; cnt=0; go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT, at each edge:
  - If shamt bit[cnt]=1, shift work by 2^cnt: SLL fills 0; SRL fills 0; SRA fills work[31].
  - If shamt bit[cnt]=0, work is unchanged.
  - cnt increments. After applying cnt=4: result<=shifted work, go to DONE.
- DONE: done=1 for exactly this cycle, busy=1. Next edge goes to IDLE.
- Latency: start high in cycle 0 → SHIFT in cycles 1-5 → done in cycle 6. Back-to-back throughput is one op per 7 cycles.
- start while busy (SHIFT or DONE) is ignored, not queued. Inputs may change freely after the accepting edge.
- result is not updated mid-shift. It changes only on the edge entering DONE.
- Boundary cases:
  - shamt=0 returns data_in unchanged.
  - shamt=31: SRA yields all copies of the sign bit; SLL/SRL leave a single surviving bit.
- Each stage is a fixed-distance shift, so no wrap-around is possible. Bits shifted out are discarded.

Optional Feature:
- Macro: SHIFT_EARLY_DONE_EN.
- Defined — early exit:
  - At the IDLE accept edge, if shamt[4:0]==0: result<=data_in and go directly to DONE (done in cycle 1).
  - In SHIFT, after applying stage cnt, if shamt bits above cnt are all zero: result<=work and go to DONE.
  - Done lands in cycle msb_index(shamt)+2. Example: shamt=1 → cycle 2, shamt=5 → cycle 4, shamt=31 → cycle 6.
  - Results are identical to the fixed-latency build.
- Undefined: fixed 6-cycle latency for every shamt, including 0.

Test Plan:
- Reset, then idle with start=0: busy=0, done=0, result=0x00000000 for 10 cycles.
- SLL data_in=0x00000001, shamt_in=0x0000001F → done in cycle 6 (feature off), result=0x80000000. shamt_in=0xFFFFFFE5 (low bits 5) → result=0x00000020.
- SRA data_in=0x80000000, shamt=4 → 0xF8000000. SRL same operands → 0x08000000. op=10 same operands → 0x08000000.
- SRL data_in=0xF0000000, shamt=28 → 0x0000000F. While busy, pulse start with data_in=0xFFFFFFFF → ignored; result stays 0x0000000F and exactly one done pulse occurs.
- Start SLL 0x12345678 by 8, assert rst in cycle 3 → next cycle busy=0, done=0, result=0. No done pulse follows. A new start after reset completes normally.
- SHIFT_EARLY_DONE_EN defined: shamt=0 with data_in=0xA5A5A5A5 → done cycle 1, result 0xA5A5A5A5. SRA 0x80000000 by 1 → done cycle 2, result 0xC0000000.
